// File: rtl/ecall_unit.sv
// ecall_unit: environment-call executor for the single-cycle core.
// Decodes the syscall number in a7 (print-int, read-int, exit), stalls the PC
// while waiting for a debounced operator confirm press, and issues a one-cycle
// write-back of the read-int result to x10.
//
// Ports:
//   clk, rst         clock (rising edge), asynchronous active-high reset
//   i_ecall          current instruction is ecall (combinational decode)
//   i_a7_data        register x17 (syscall number)
//   i_a0_data        register x10 (print-int argument)
//   i_conf_btn       raw confirm pushbutton, asynchronous, high = pressed
//   i_switch_data    raw 13-bit switch bank
//   o_stall          hold PC / suppress core regWrite (combinational)
//   o_wb_en          write o_wb_data to o_wb_addr this cycle (registered)
//   o_wb_addr        constant 5'd10
//   o_wb_data        read-int result
//   o_disp_data      last printed value
//   o_disp_valid     print in progress
//   o_halted         program exited
//
// Optional feature macro: ECALL_READ_SIGN_EXT_EN
//   defined   -> read-int sign-extends switch bit 12 into bits 31:13
//   undefined -> read-int zero-extends the switch bank
module ecall_unit #(
  parameter int unsigned DEBOUNCE_CYCLES = 1000000,
  parameter int unsigned SYS_PRINT       = 1,
  parameter int unsigned SYS_READ        = 5,
  parameter int unsigned SYS_EXIT        = 10
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        i_ecall,
  input  logic [31:0] i_a7_data,
  input  logic [31:0] i_a0_data,
  input  logic        i_conf_btn,
  input  logic [12:0] i_switch_data,
  output logic        o_stall,
  output logic        o_wb_en,
  output logic [4:0]  o_wb_addr,
  output logic [31:0] o_wb_data,
  output logic [31:0] o_disp_data,
  output logic        o_disp_valid,
  output logic        o_halted
);

  // Counter only has to reach DEBOUNCE_CYCLES-1; keep at least one bit.
  localparam int unsigned CNT_W = (DEBOUNCE_CYCLES > 1) ? $clog2(DEBOUNCE_CYCLES) : 1;
  localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic [2:0] {
    S_IDLE       = 3'd0,
    S_PRINT_WAIT = 3'd1,
    S_READ_WAIT  = 3'd2,
    S_DONE       = 3'd3,
    S_HALT       = 3'd4
  } state_t;

  state_t           r_state;
  logic             r_sync1;
  logic             r_sync2;
  logic             r_stable;
  logic             r_press;
  logic [CNT_W-1:0] r_cnt;
  logic             r_wb_en;
  logic [31:0]      r_wb_data;
  logic [31:0]      r_disp_data;
  logic             r_disp_valid;
  logic             r_halted;

  logic             w_is_print;
  logic             w_is_read;
  logic             w_is_exit;
  logic             w_call;
  logic [31:0]      w_read_ext;

  // Full 32-bit syscall decode
  assign w_is_print = (i_a7_data == 32'(SYS_PRINT));
  assign w_is_read  = (i_a7_data == 32'(SYS_READ));
  assign w_is_exit  = (i_a7_data == 32'(SYS_EXIT));
  assign w_call     = i_ecall && (w_is_print || w_is_read || w_is_exit);

`ifdef ECALL_READ_SIGN_EXT_EN
  assign w_read_ext = {{19{i_switch_data[12]}}, i_switch_data};
`else
  assign w_read_ext = {19'b0, i_switch_data};
`endif

  // Stall in the ecall cycle itself, then for every waiting/halted state.
  // Forced low while rst is held so an aborted call releases the PC at once.
  assign o_stall = !rst && (((r_state == S_IDLE) && w_call) ||
                            (r_state == S_PRINT_WAIT) ||
                            (r_state == S_READ_WAIT)  ||
                            (r_state == S_HALT));

  // Button synchroniser, debouncer and rising-edge press pulse
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sync1  <= 1'b0;
      r_sync2  <= 1'b0;
      r_stable <= 1'b0;
      r_press  <= 1'b0;
      r_cnt    <= '0;
    end else begin
      r_sync1 <= i_conf_btn;
      r_sync2 <= r_sync1;
      r_press <= (r_sync2 != r_stable) && (r_cnt == CNT_MAX) && r_sync2;
      if (r_sync2 == r_stable) begin
        r_cnt <= '0;
      end else if (r_cnt == CNT_MAX) begin
        r_cnt    <= '0;
        r_stable <= r_sync2;
      end else begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

  // Call sequencing FSM with registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state      <= S_IDLE;
      r_wb_en      <= 1'b0;
      r_wb_data    <= '0;
      r_disp_data  <= '0;
      r_disp_valid <= 1'b0;
      r_halted     <= 1'b0;
    end else begin
      r_wb_en <= 1'b0;
      case (r_state)
        S_IDLE: begin
          // Presses arriving here are simply not looked at
          if (i_ecall) begin
            if (w_is_print) begin
              r_state      <= S_PRINT_WAIT;
              r_disp_data  <= i_a0_data;
              r_disp_valid <= 1'b1;
            end else if (w_is_read) begin
              r_state <= S_READ_WAIT;
            end else if (w_is_exit) begin
              r_state  <= S_HALT;
              r_halted <= 1'b1;
            end
          end
        end
        S_PRINT_WAIT: begin
          if (r_press) begin
            r_state      <= S_DONE;
            r_disp_valid <= 1'b0;
          end
        end
        S_READ_WAIT: begin
          if (r_press) begin
            r_state   <= S_DONE;
            r_wb_en   <= 1'b1;
            r_wb_data <= w_read_ext;
          end
        end
        // One cycle with stall low; ecall still on the bus is ignored here
        S_DONE:  r_state <= S_IDLE;
        S_HALT:  r_state <= S_HALT;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_wb_en      = r_wb_en;
  assign o_wb_addr    = 5'd10;
  assign o_wb_data    = r_wb_data;
  assign o_disp_data  = r_disp_data;
  assign o_disp_valid = r_disp_valid;
  assign o_halted     = r_halted;

endmodule
